// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds the hex digits shown on a multiplexed 7-segment bus
module seg7_scan_capture #(
    parameter int DIGITS = 8,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     dvalid,
    output logic [DIGITS-1:0]     blank,
    output logic                  frame_done,
    output logic                  pat_err,
    output logic                  an_err,
    output logic [2:0]            err_idx
);
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic [3:0]          r_cnt;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]   r_dvalid;
    logic [DIGITS-1:0]   r_blank;
    logic                r_frame;
    logic                r_pat_err;
    logic                r_an_err;
    logic [2:0]          r_err_idx;
    logic                w_same;
    logic                w_cap;
    logic                w_multi;
    logic                w_one;
    logic                w_hit;
    logic                w_dark;
    logic [3:0]          w_nib;
    logic [2:0]          w_idx;
    logic [DIGITS-1:0]   w_seen_nx;

    // the incoming pair is compared with the registered one, so the first cycle of a new value loads 0
    assign w_same    = (seg == r_seg) && (an == r_an);
    assign w_cap     = w_same && (r_cnt == 4'(STABLE - 1));
    assign w_multi   = |(r_an & (r_an - DIGITS'(1)));
    assign w_one     = (r_an != '0) && !w_multi;
    assign w_dark    = (r_seg == 7'h00);
    assign w_seen_nx = r_seen | r_an;

    // segment pattern to nibble lookup; blank and unknown patterns both miss
    always_comb begin
        w_hit = 1'b1;
        w_nib = 4'h0;
        case (r_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    // index of the active anode, only meaningful when it is one-hot
    always_comb begin
        w_idx = 3'd0;
        for (int k = 0; k < DIGITS; k++)
            if (r_an[k]) w_idx = 3'(k);
    end

    // input registers and the saturating stability counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_seg <= '0;
            r_an  <= '0;
            r_cnt <= '0;
        end else begin
            r_seg <= seg;
            r_an  <= an;
            r_cnt <= !w_same ? 4'd0 : (r_cnt == 4'(STABLE)) ? r_cnt : r_cnt + 4'd1;
        end
    end

    // capture: update the addressed digit, raise error pulses and close the frame
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_seen    <= '0;
            r_digits  <= '0;
            r_dvalid  <= '0;
            r_blank   <= '0;
            r_frame   <= 1'b0;
            r_pat_err <= 1'b0;
            r_an_err  <= 1'b0;
            r_err_idx <= 3'd0;
        end else begin
            r_frame   <= 1'b0;
            r_pat_err <= 1'b0;
            r_an_err  <= w_cap && w_multi;
            if (w_cap && w_one) begin
                r_seen  <= (&w_seen_nx) ? '0 : w_seen_nx;
                r_frame <= &w_seen_nx;
                if (!w_hit && !w_dark) begin
                    r_pat_err <= 1'b1;
                    r_err_idx <= w_idx;
                end
                for (int k = 0; k < DIGITS; k++) begin
                    if (r_an[k]) begin
                        r_dvalid[k] <= w_hit;
                        r_blank[k]  <= w_dark;
                        if (w_hit || w_dark) r_digits[4*k +: 4] <= w_nib;
                    end
                end
            end
        end
    end

    assign digits     = r_digits;
    assign dvalid     = r_dvalid;
    assign blank      = r_blank;
    assign frame_done = r_frame;
    assign pat_err    = r_pat_err;
    assign an_err     = r_an_err;
    assign err_idx    = r_err_idx;
endmodule
